adder_bist_ctrl: RTL and testbench

- BIST sequencer for the N-bit adder datapath behind the 2:1 operand mux (pin operands vs. internal operands).
- On start it drives the mux select to the internal side and feeds pseudo-random operands from an LFSR.
- It compacts each {cout,sum} result into a MISR, then compares the final signature with a golden value and reports pass/fail.

---
 rtl/adder_bist_pkg.sv | 21 ++
 rtl/bist_misr.sv | 42 ++++
 rtl/adder_bist_ctrl.sv | 167 ++++++++++++++++
 tb/tb_adder_bist_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST controller.
// Holds the FSM state encoding and the default LFSR/MISR polynomials and seeds
// for the 16-bit adder configuration (LFSR width 2N+1 = 33, MISR width N+1 = 17).
package adder_bist_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StCheck = 3'd4
  } bist_state_e;

  // x^33 + x^20 + 1, Fibonacci tap mask
  localparam logic [32:0] DefLfsrPoly = 33'h1_0008_0000;
  localparam logic [32:0] DefLfsrSeed = 33'h0_0000_0001;
  // x^17 + x^14 + 1, Galois feedback mask
  localparam logic [16:0] DefMisrPoly = 17'h04001;
  localparam logic [16:0] DefMisrSeed = 17'h00000;

endpackage

// File: rtl/bist_misr.sv
// Galois-style multiple-input signature register.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (resets to Seed)
//   load_i        : reload Seed (has priority over en_i)
//   en_i          : shift and absorb data_i this cycle
//   data_i        : parallel input word
//   sig_o         : current signature
module bist_misr #(
  parameter int unsigned     W    = 17,
  parameter logic [W-1:0]    Poly = '0,
  parameter logic [W-1:0]    Seed = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sig_o
);

  logic [W-1:0] sig_d, sig_q;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = Seed;
    end else if (en_i) begin
      sig_d = ({sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? Poly : '0)) ^ data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= Seed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/adder_bist_ctrl.sv
// BIST sequencer for an N-bit adder sitting behind a 2:1 operand mux.
// On an accepted start it switches the mux to the internal operands, streams
// LFSR patterns through the adder, compacts {cout,sum} into a MISR and compares
// the final signature with golden_sig_i.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   start_i, abort_i       : run request (ignored while busy); abort wins
//   num_pat_i              : pattern count, latched on accepted start
//   golden_sig_i           : expected signature, sampled in CHECK
//   sum_in_i, cout_in_i    : adder result
//   sel_o                  : 1 = adder fed from bist_a/b/cin
//   bist_a_o/b_o/cin_o     : operands taken from the LFSR
//   busy_o, done_o, pass_o : status (pass valid while done)
//   signature_o            : live MISR contents
// Build option: define ADDER_BIST_CTRL_PIPE_CAPTURE_EN to register the adder
// result before the MISR; a DRAIN state then absorbs the last result.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int unsigned    N         = 16,
  parameter int unsigned    CNT_W     = 16,
  parameter logic [2*N:0]   LFSR_SEED = DefLfsrSeed,
  parameter logic [2*N:0]   LFSR_POLY = DefLfsrPoly,
  parameter logic [N:0]     MISR_SEED = DefMisrSeed,
  parameter logic [N:0]     MISR_POLY = DefMisrPoly
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_pat_i,
  input  logic [N:0]       golden_sig_i,
  input  logic [N-1:0]     sum_in_i,
  input  logic             cout_in_i,
  output logic             sel_o,
  output logic [N-1:0]     bist_a_o,
  output logic [N-1:0]     bist_b_o,
  output logic             bist_cin_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [N:0]       signature_o
);

  // A zero seed would lock the LFSR at zero.
  localparam logic [2*N:0] LfsrSeedEff =
      (LFSR_SEED == '0) ? {{(2*N){1'b0}}, 1'b1} : LFSR_SEED;

  bist_state_e      state_q;
  logic [2*N:0]     lfsr_q;
  logic [CNT_W-1:0] cnt_q, num_pat_q;
  logic             sel_q, busy_q, done_q, pass_q;

  logic             misr_load, misr_en, last_pat, lfsr_fb;
  logic [N:0]       misr_data, misr_sig;

  assign last_pat = (cnt_q == num_pat_q - CNT_W'(1));
  assign lfsr_fb  = ^(lfsr_q & LFSR_POLY);

`ifdef ADDER_BIST_CTRL_PIPE_CAPTURE_EN
  logic [N:0] cap_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_q <= '0;
    end else if (state_q == StRun) begin
      cap_q <= {cout_in_i, sum_in_i};
    end
  end

  // MISR lags the adder by one cycle: the first RUN cycle has nothing captured
  // yet, and DRAIN absorbs the final pattern.
  always_comb begin
    misr_load = (state_q == StLoad) && !abort_i;
    misr_en   = !abort_i && (((state_q == StRun) && (cnt_q != '0)) || (state_q == StDrain));
    misr_data = cap_q;
  end
`else
  always_comb begin
    misr_load = (state_q == StLoad) && !abort_i;
    misr_en   = (state_q == StRun) && !abort_i;
    misr_data = {cout_in_i, sum_in_i};
  end
`endif

  bist_misr #(
    .W    (N + 1),
    .Poly (MISR_POLY),
    .Seed (MISR_SEED)
  ) u_misr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (misr_load),
    .en_i   (misr_en),
    .data_i (misr_data),
    .sig_o  (misr_sig)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      lfsr_q    <= LfsrSeedEff;
      cnt_q     <= '0;
      num_pat_q <= '0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else if (abort_i) begin
      // LFSR and MISR deliberately hold for post-mortem inspection.
      state_q <= StIdle;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            num_pat_q <= num_pat_i;
            state_q   <= StLoad;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        StLoad: begin
          lfsr_q  <= LfsrSeedEff;
          cnt_q   <= '0;
          sel_q   <= 1'b1;
          state_q <= (num_pat_q == '0) ? StCheck : StRun;
        end
        StRun: begin
          lfsr_q <= {lfsr_q[2*N-1:0], lfsr_fb};
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_pat) begin
`ifdef ADDER_BIST_CTRL_PIPE_CAPTURE_EN
            state_q <= StDrain;
`else
            state_q <= StCheck;
`endif
          end
        end
`ifdef ADDER_BIST_CTRL_PIPE_CAPTURE_EN
        StDrain: state_q <= StCheck;
`endif
        StCheck: begin
          pass_q  <= (misr_sig == golden_sig_i);
          done_q  <= 1'b1;
          sel_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sel_o       = sel_q;
  assign bist_a_o    = lfsr_q[2*N:N+1];
  assign bist_b_o    = lfsr_q[N:1];
  assign bist_cin_o  = lfsr_q[0];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign signature_o = misr_sig;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Directed bench for adder_bist_ctrl with a behavioural operand mux + adder
// in the loop and an independent LFSR/MISR reference for expected signatures.
module tb_adder_bist_ctrl;

  localparam int unsigned N     = 16;
  localparam int unsigned CNT_W = 16;
`ifdef ADDER_BIST_CTRL_PIPE_CAPTURE_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [CNT_W-1:0] num_pat_i = '0;
  logic [N:0]       golden_sig_i = '0;
  logic [N-1:0]     sum_in_i;
  logic             cout_in_i;
  logic             sel_o, bist_cin_o, busy_o, done_o, pass_o;
  logic [N-1:0]     bist_a_o, bist_b_o;
  logic [N:0]       signature_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  // Operand mux (device pins tied to zero) feeding a combinational adder.
  logic [N-1:0] mux_a, mux_b;
  logic         mux_cin;
  always_comb begin
    mux_a   = sel_o ? bist_a_o : '0;
    mux_b   = sel_o ? bist_b_o : '0;
    mux_cin = sel_o ? bist_cin_o : 1'b0;
    {cout_in_i, sum_in_i} = {1'b0, mux_a} + {1'b0, mux_b} + {{N{1'b0}}, mux_cin};
  end

  adder_bist_ctrl u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .num_pat_i    (num_pat_i),
    .golden_sig_i (golden_sig_i),
    .sum_in_i     (sum_in_i),
    .cout_in_i    (cout_in_i),
    .sel_o        (sel_o),
    .bist_a_o     (bist_a_o),
    .bist_b_o     (bist_b_o),
    .bist_cin_o   (bist_cin_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .signature_o  (signature_o)
  );

  function automatic logic [16:0] ref_sig(input int n);
    logic [32:0] l;
    logic [16:0] m, r;
    l = 33'h0_0000_0001;
    m = 17'h00000;
    for (int i = 0; i < n; i++) begin
      r = {1'b0, l[32:17]} + {1'b0, l[16:1]} + {16'h0, l[0]};
      m = ({m[15:0], 1'b0} ^ (m[16] ? 17'h04001 : 17'h00000)) ^ r;
      l = {l[31:0], l[32] ^ l[19]};
    end
    return m;
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    n_cmp++; if (sel_o !== 1'b0) begin n_err++; $display("FAIL reset_sel: got %b want 0", sel_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_cmp++; if (pass_o !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %b want 0", pass_o); end
    n_cmp++; if (signature_o !== 17'h0) begin n_err++; $display("FAIL reset_sig: got %h want 0", signature_o); end
    n_cmp++;
    if ({bist_a_o, bist_b_o, bist_cin_o} !== 33'h1) begin
      n_err++; $display("FAIL reset_lfsr: got %h/%h/%b want 0/0/1", bist_a_o, bist_b_o, bist_cin_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
  endtask

  // Start a run and follow it to done, checking latency, busy/sel duration and result.
  task automatic run_case(input string nm, input int n, input logic [16:0] golden,
                          input logic [16:0] exp_sig, input logic exp_pass);
    int lat, busy_cnt, sel_cnt, exp_lat, exp_sel;
    exp_lat = n + 2 + ((n > 0) ? Extra : 0);
    exp_sel = n + 1 + ((n > 0) ? Extra : 0);
    start_i = 1'b1; num_pat_i = CNT_W'(n); golden_sig_i = golden;
    cyc();
    start_i = 1'b0;
    lat = 0; busy_cnt = 0; sel_cnt = 0;
    while (!done_o && lat < n + 10) begin
      busy_cnt += int'(busy_o);
      sel_cnt  += int'(sel_o);
      cyc();
      lat++;
    end
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL %s_done: got %b want 1", nm, done_o); end
    n_cmp++; if (lat != exp_lat) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, exp_lat); end
    n_cmp++; if (busy_cnt != exp_lat) begin n_err++; $display("FAIL %s_busy_len: got %0d want %0d", nm, busy_cnt, exp_lat); end
    n_cmp++; if (sel_cnt != exp_sel) begin n_err++; $display("FAIL %s_sel_len: got %0d want %0d", nm, sel_cnt, exp_sel); end
    n_cmp++; if (signature_o !== exp_sig) begin n_err++; $display("FAIL %s_sig: got %h want %h", nm, signature_o, exp_sig); end
    n_cmp++; if (pass_o !== exp_pass) begin n_err++; $display("FAIL %s_pass: got %b want %b", nm, pass_o, exp_pass); end
    n_cmp++; if ({sel_o, busy_o} !== 2'b00) begin n_err++; $display("FAIL %s_idle: got sel/busy %b%b want 00", nm, sel_o, busy_o); end
    cyc();
    n_cmp++;
    if ({done_o, signature_o} !== {1'b1, exp_sig}) begin
      n_err++; $display("FAIL %s_hold: got %b/%h want 1/%h", nm, done_o, signature_o, exp_sig);
    end
  endtask

  task automatic test_patterns();
    run_case("np0", 0, 17'h00000, 17'h00000, 1'b1);
    run_case("np1", 1, 17'h00001, 17'h00001, 1'b1);
    run_case("np2", 2, 17'h00004, 17'h00003, 1'b0);
    run_case("np100", 100, ref_sig(100), ref_sig(100), 1'b1);
  endtask

  task automatic test_abort();
    logic [16:0] sig_before;
    logic [15:0] a_before;
    // Abort while idle clears a standing done/pass.
    abort_i = 1'b1; cyc(); abort_i = 1'b0;
    n_cmp++; if ({done_o, pass_o} !== 2'b00) begin n_err++; $display("FAIL abort_idle: got done/pass %b%b want 00", done_o, pass_o); end
    start_i = 1'b1; num_pat_i = 16'd20; cyc(); start_i = 1'b0;
    repeat (6) cyc();
    sig_before = signature_o;
    a_before   = bist_a_o;
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL abort_prebusy: got %b want 1", busy_o); end
    abort_i = 1'b1; cyc(); abort_i = 1'b0;
    n_cmp++;
    if ({sel_o, busy_o, done_o, pass_o} !== 4'b0000) begin
      n_err++; $display("FAIL abort_outs: got sel/busy/done/pass %b%b%b%b want 0000", sel_o, busy_o, done_o, pass_o);
    end
    n_cmp++; if (signature_o !== sig_before) begin n_err++; $display("FAIL abort_misr_hold: got %h want %h", signature_o, sig_before); end
    n_cmp++; if (bist_a_o !== a_before) begin n_err++; $display("FAIL abort_lfsr_hold: got %h want %h", bist_a_o, a_before); end
    cyc();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_stay_idle: got %b want 0", busy_o); end
  endtask

  task automatic test_start_ignored();
    int lat;
    start_i = 1'b1; num_pat_i = 16'd10; golden_sig_i = ref_sig(10); cyc(); start_i = 1'b0;
    repeat (4) cyc();
    start_i = 1'b1; num_pat_i = 16'd3; cyc(); start_i = 1'b0;
    lat = 5;
    while (!done_o && lat < 30) begin cyc(); lat++; end
    n_cmp++; if (lat != 12 + Extra) begin n_err++; $display("FAIL busy_start_latency: got %0d want %0d", lat, 12 + Extra); end
    n_cmp++; if (signature_o !== ref_sig(10)) begin n_err++; $display("FAIL busy_start_sig: got %h want %h", signature_o, ref_sig(10)); end
    n_cmp++; if (pass_o !== 1'b1) begin n_err++; $display("FAIL busy_start_pass: got %b want 1", pass_o); end
    cyc();
  endtask

  task automatic test_start_abort();
    start_i = 1'b1; abort_i = 1'b1; num_pat_i = 16'd5; cyc();
    start_i = 1'b0; abort_i = 1'b0;
    n_cmp++;
    if ({busy_o, sel_o, done_o} !== 3'b000) begin
      n_err++; $display("FAIL start_abort: got busy/sel/done %b%b%b want 000", busy_o, sel_o, done_o);
    end
    repeat (2) cyc();
    n_cmp++; if ({busy_o, sel_o} !== 2'b00) begin n_err++; $display("FAIL start_abort_idle: got %b%b want 00", busy_o, sel_o); end
  endtask

  task automatic test_reset_mid_run();
    start_i = 1'b1; num_pat_i = 16'd50; cyc(); start_i = 1'b0;
    repeat (8) cyc();
    n_cmp++; if (sel_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_presel: got %b want 1", sel_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({sel_o, busy_o, done_o, pass_o} !== 4'b0000) begin
      n_err++; $display("FAIL rst_mid_outs: got sel/busy/done/pass %b%b%b%b want 0000", sel_o, busy_o, done_o, pass_o);
    end
    n_cmp++; if (signature_o !== 17'h0) begin n_err++; $display("FAIL rst_mid_sig: got %h want 0", signature_o); end
    n_cmp++; if (bist_cin_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_lfsr: got %b want 1", bist_cin_o); end
    #2 rst_ni = 1'b1;
    repeat (60) cyc();
    n_cmp++; if ({busy_o, done_o} !== 2'b00) begin n_err++; $display("FAIL rst_mid_no_done: got %b%b want 00", busy_o, done_o); end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_abort();
    test_start_ignored();
    test_start_abort();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
